// File: rtl/vlsu_cam_top.sv
// Multi-port CAM for the VLSU: addressed writes, masked full-width searches, oldest-first priority.
// Optional macro VLSU_CAM_WRITE_BYPASS_EN forwards same-cycle writes into that cycle's searches.
module vlsu_cam_top #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 32,
    parameter int WRITE = 1,
    parameter int READ  = 3,
    localparam int ADDRESS = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDRESS-1:0]               head_i,
    input  logic [READ-1:0][DEPTH-1:0]       enable_i,
    input  logic [WRITE-1:0]                 write_i,
    input  logic [WRITE-1:0][ADDRESS-1:0]    write_addr_i,
    input  logic [WRITE-1:0][WIDTH-1:0]      write_data_i,
    input  logic [READ-1:0]                  read_i,
    input  logic [READ-1:0][WIDTH-1:0]       read_data_i,
    output logic [READ-1:0]                  match_o,
    output logic [READ-1:0][ADDRESS-1:0]     match_data_o
);

    logic [WIDTH-1:0]              r_data [DEPTH];
    logic [DEPTH-1:0]              r_valid;
    logic [READ-1:0]               r_match;
    logic [READ-1:0][ADDRESS-1:0]  r_match_data;

    logic [WIDTH-1:0]              w_cmp_data [DEPTH];
    logic [DEPTH-1:0]              w_cmp_valid;
    logic [DEPTH-1:0]              w_hit [READ];
    logic [READ-1:0]               w_any;
    logic [ADDRESS-1:0]            w_win [READ];

    // Array view seen by the comparators (optionally including this cycle's writes)
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_cmp_data[e]  = r_data[e];
            w_cmp_valid[e] = r_valid[e];
`ifdef VLSU_CAM_WRITE_BYPASS_EN
            for (int w = 0; w < WRITE; w++) begin
                w_cmp_data[e]  = (write_i[w] && (write_addr_i[w] == ADDRESS'(e))) ?
                                 write_data_i[w] : w_cmp_data[e];
                w_cmp_valid[e] = (write_i[w] && (write_addr_i[w] == ADDRESS'(e))) ?
                                 1'b1 : w_cmp_valid[e];
            end
`endif
        end
    end

    // Per-port, per-entry hit vector
    always_comb begin
        for (int r = 0; r < READ; r++) begin
            for (int e = 0; e < DEPTH; e++) begin
                w_hit[r][e] = w_cmp_valid[e] & enable_i[r][e] &
                              (w_cmp_data[e] == read_data_i[r]);
            end
        end
    end

    // Wrap-around priority from head_i: scan backwards so the nearest hit is assigned last
    always_comb begin
        for (int r = 0; r < READ; r++) begin
            w_win[r] = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (w_hit[r][head_i + ADDRESS'(k)]) begin
                    w_win[r] = head_i + ADDRESS'(k);
                end else begin
                    w_win[r] = w_win[r];
                end
            end
            w_any[r] = |w_hit[r];
        end
    end

    // Entry storage; later write ports override earlier ones on the same address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_data[e] <= '0;
            end
        end else begin
            for (int w = 0; w < WRITE; w++) begin
                if (write_i[w]) begin
                    r_data[write_addr_i[w]]  <= write_data_i[w];
                    r_valid[write_addr_i[w]] <= 1'b1;
                end
            end
        end
    end

    // Registered search results; idle ports report zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match      <= '0;
            r_match_data <= '0;
        end else begin
            for (int r = 0; r < READ; r++) begin
                r_match[r]      <= read_i[r] & w_any[r];
                r_match_data[r] <= read_i[r] ? w_win[r] : {ADDRESS{1'b0}};
            end
        end
    end

    assign match_o      = r_match;
    assign match_data_o = r_match_data;

endmodule

// File: tb/tb_vlsu_cam_top.sv
// Self-checking bench for vlsu_cam_top: table of search vectors plus hand-written corner sequences.
module tb_vlsu_cam_top;
    localparam int WIDTH   = 50;
    localparam int DEPTH   = 32;
    localparam int WRITE   = 1;
    localparam int READ    = 3;
    localparam int ADDRESS = 5;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [ADDRESS-1:0]            head_i;
    logic [READ-1:0][DEPTH-1:0]    enable_i;
    logic [WRITE-1:0]              write_i;
    logic [WRITE-1:0][ADDRESS-1:0] write_addr_i;
    logic [WRITE-1:0][WIDTH-1:0]   write_data_i;
    logic [READ-1:0]               read_i;
    logic [READ-1:0][WIDTH-1:0]    read_data_i;
    logic [READ-1:0]               match_o;
    logic [READ-1:0][ADDRESS-1:0]  match_data_o;

    vlsu_cam_top #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRITE(WRITE), .READ(READ)) dut (
        .clk          (clk),
        .rst          (rst),
        .head_i       (head_i),
        .enable_i     (enable_i),
        .write_i      (write_i),
        .write_addr_i (write_addr_i),
        .write_data_i (write_data_i),
        .read_i       (read_i),
        .read_data_i  (read_data_i),
        .match_o      (match_o),
        .match_data_o (match_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                        name;
        logic [READ-1:0]              m;
        logic [READ-1:0][ADDRESS-1:0] d;
    } exp_t;

    typedef struct {
        string                        name;
        logic [WIDTH-1:0]             key;
        logic [ADDRESS-1:0]           head;
        logic [DEPTH-1:0]             en1;
        logic [READ-1:0]              m;
        logic [READ-1:0][ADDRESS-1:0] d;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [READ-1:0][ADDRESS-1:0] mk3(input logic [ADDRESS-1:0] a,
                                                         input logic [ADDRESS-1:0] b,
                                                         input logic [ADDRESS-1:0] c);
        logic [READ-1:0][ADDRESS-1:0] t;
        t[0] = a;
        t[1] = b;
        t[2] = c;
        return t;
    endfunction

    function automatic vec_t mkv(input string nm, input logic [WIDTH-1:0] key,
                                 input logic [ADDRESS-1:0] head, input logic [DEPTH-1:0] en1,
                                 input logic [READ-1:0] m, input logic [READ-1:0][ADDRESS-1:0] d);
        vec_t v;
        v.name = nm; v.key = key; v.head = head; v.en1 = en1; v.m = m; v.d = d;
        return v;
    endfunction

    // Push the expectation for the current drive, clock once, then pop and compare
    task automatic step(input string nm, input logic [READ-1:0] em,
                        input logic [READ-1:0][ADDRESS-1:0] ed);
        exp_t e;
        e.name = nm; e.m = em; e.d = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        write_i = '0;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            total++;
            if (match_o !== e.m) begin
                bad++;
                $display("FAIL %s match_o: got %b want %b", e.name, match_o, e.m);
            end
            for (int r = 0; r < READ; r++) begin
                total++;
                if (match_data_o[r] !== e.d[r]) begin
                    bad++;
                    $display("FAIL %s match_data_o[%0d]: got %0d want %0d",
                             e.name, r, match_data_o[r], e.d[r]);
                end
            end
        end
    endtask

    task automatic search_all(input logic [WIDTH-1:0] key);
        read_i = 3'b111;
        for (int r = 0; r < READ; r++) read_data_i[r] = key;
    endtask

    task automatic fill();
        read_i = '0;
        for (int j = 0; j < DEPTH; j++) begin
            write_i         = 1'b1;
            write_addr_i[0] = ADDRESS'(j);
            write_data_i[0] = (j < 16) ? WIDTH'(j + 1) : WIDTH'(j - 15);
            step("fill_idle", 3'b000, mk3(5'd0, 5'd0, 5'd0));
        end
    endtask

    localparam logic [WIDTH-1:0] BIG = 50'h3_FFFF_FFFF_FFFF;

    initial begin
        // Search vectors over the duplicate-key fill (key k lives at k-1 and k+15)
        for (int k = 1; k <= 16; k++)
            vecs.push_back(mkv("prio_head0", WIDTH'(k), 5'd0, '1, 3'b111,
                               mk3(5'(k - 1), 5'(k - 1), 5'(k - 1))));
        vecs.push_back(mkv("wrap_h20_k4", 50'd4, 5'd20, '1, 3'b111, mk3(5'd3, 5'd3, 5'd3)));
        vecs.push_back(mkv("wrap_h20_k8", 50'd8, 5'd20, '1, 3'b111, mk3(5'd23, 5'd23, 5'd23)));
        vecs.push_back(mkv("wrap_h5_k4", 50'd4, 5'd5, '1, 3'b111, mk3(5'd19, 5'd19, 5'd19)));
        vecs.push_back(mkv("wrap_h31_k16", 50'd16, 5'd31, '1, 3'b111, mk3(5'd31, 5'd31, 5'd31)));
        vecs.push_back(mkv("mask_bit2", 50'd3, 5'd0, 32'hFFFF_FFFB, 3'b111,
                           mk3(5'd2, 5'd18, 5'd2)));
        vecs.push_back(mkv("mask_all0", 50'd3, 5'd0, 32'h0000_0000, 3'b101,
                           mk3(5'd2, 5'd0, 5'd2)));
        vecs.push_back(mkv("miss_key99", 50'd99, 5'd0, '1, 3'b000, mk3(5'd0, 5'd0, 5'd0)));

        rst = 1'b1; head_i = '0; enable_i = '1; write_i = '0; write_addr_i = '0;
        write_data_i = '0; read_i = '0; read_data_i = '0;
        step("reset", 3'b000, mk3(5'd0, 5'd0, 5'd0));
        rst = 1'b0;

        search_all(50'd0);
        step("empty_key0", 3'b000, mk3(5'd0, 5'd0, 5'd0));
        search_all(50'd7);
        step("empty_key7", 3'b000, mk3(5'd0, 5'd0, 5'd0));

        fill();

        foreach (vecs[i]) begin
            head_i      = vecs[i].head;
            enable_i    = '1;
            enable_i[1] = vecs[i].en1;
            search_all(vecs[i].key);
            step(vecs[i].name, vecs[i].m, vecs[i].d);
        end
        enable_i = '1;
        head_i   = '0;

        // A hit followed by an idle cycle must fall back to zero
        read_i = '0;
        step("idle_after_hit", 3'b000, mk3(5'd0, 5'd0, 5'd0));

        // Overwrite entry 9 with a key searched in the same cycle
        write_i = 1'b1; write_addr_i[0] = 5'd9; write_data_i[0] = BIG;
        read_i = 3'b001; read_data_i[0] = BIG;
`ifdef VLSU_CAM_WRITE_BYPASS_EN
        step("same_cycle_write", 3'b001, mk3(5'd9, 5'd0, 5'd0));
`else
        step("same_cycle_write", 3'b000, mk3(5'd0, 5'd0, 5'd0));
`endif
        step("search_after_write", 3'b001, mk3(5'd9, 5'd0, 5'd0));
        search_all(50'd10);
        step("overwritten_key10", 3'b111, mk3(5'd25, 5'd25, 5'd25));

        // Reset in the middle of searching wipes outputs and contents
        search_all(50'd1);
        rst = 1'b1;
        step("reset_mid_search", 3'b000, mk3(5'd0, 5'd0, 5'd0));
        rst = 1'b0;
        search_all(50'd1);
        step("post_reset_key1", 3'b000, mk3(5'd0, 5'd0, 5'd0));
        search_all(BIG);
        step("post_reset_big", 3'b000, mk3(5'd0, 5'd0, 5'd0));
        search_all(50'd0);
        step("post_reset_key0", 3'b000, mk3(5'd0, 5'd0, 5'd0));

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
